// File: rtl/common_pkg.sv
// Shared decode types and helpers for the decode stage.
// Holds the instruction/branch/control types, the base opcode constants
// and the two pure decode functions (control bundle and immediate).
package common;

  typedef logic [31:0] instruction_type;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } branch_predict_type;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src_imm;
    logic [3:0] alu_op;
  } control_type;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Unknown opcodes fall through to an all-zero bundle, which EX treats as NOP.
  function automatic control_type decode_control(input instruction_type instr);
    control_type c;
    c = '0;
    case (instr[6:0])
      OPC_OP: begin
        c.reg_write = 1'b1;
        c.alu_op    = {instr[30], instr[14:12]};
      end
      OPC_OP_IMM: begin
        c.reg_write   = 1'b1;
        c.alu_src_imm = 1'b1;
        // Only the shift-right encoding uses bit 30 to pick arithmetic vs logical.
        c.alu_op      = {(instr[14:12] == 3'b101) ? instr[30] : 1'b0, instr[14:12]};
      end
      OPC_LOAD: begin
        c.reg_write   = 1'b1;
        c.mem_read    = 1'b1;
        c.alu_src_imm = 1'b1;
      end
      OPC_STORE: begin
        c.mem_write   = 1'b1;
        c.alu_src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        c.alu_op = {1'b0, instr[14:12]};
      end
      OPC_JAL: begin
        c.reg_write = 1'b1;
        c.jump      = 1'b1;
      end
      OPC_JALR: begin
        c.reg_write   = 1'b1;
        c.jump        = 1'b1;
        c.alu_src_imm = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        c.reg_write   = 1'b1;
        c.alu_src_imm = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] decode_immediate(input instruction_type instr);
    logic [31:0] imm;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file for the decode stage.
// Ports: clk/rst (sync, active-high); NUM_WR write ports (write_en,
// write_id, write_data); two combinational read ports rs1/rs2.
// Register 0 is never written and always reads zero. When several ports
// hit the same register in one cycle the highest port index wins, both
// for the stored value and for the same-cycle bypass.
module id_regfile
  import common::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_WR    = 2,
  parameter int BYPASS_EN = 1,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WR-1:0]              write_en,
  input  logic [NUM_WR-1:0][RW-1:0]      write_id,
  input  logic [NUM_WR-1:0][XLEN-1:0]    write_data,
  input  logic [RW-1:0]                  rs1_id,
  input  logic [RW-1:0]                  rs2_id,
  output logic [XLEN-1:0]                rs1_data,
  output logic [XLEN-1:0]                rs2_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Ascending port loop: later non-blocking writes override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (write_en[p] && (write_id[p] != '0)) regs[write_id[p]] <= write_data[p];
      end
    end
  end

  always_comb begin
    rs1_data = (rs1_id == '0) ? '0 : regs[rs1_id];
    rs2_data = (rs2_id == '0) ? '0 : regs[rs2_id];
    if (BYPASS_EN != 0) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (write_en[p] && (write_id[p] == rs1_id) && (rs1_id != '0)) rs1_data = write_data[p];
        if (write_en[p] && (write_id[p] == rs2_id) && (rs2_id != '0)) rs2_data = write_data[p];
      end
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage between IF and EX.
// Ports: clk/rst (sync, active-high); IF side in_valid/in_ready with
// instruction, pc, branch_in and flush; write-back ports write_en/id/data;
// EX side out_valid/out_ready with branch_out, reg_rd_id, pc_out,
// read_data1/2, immediate_data, control_signals.
// The output bundle is a single pipeline register. While EX stalls the
// held operands keep tracking write-back to their source registers so EX
// never consumes a stale value.
module id_stage_pipe
  import common::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_WR    = 2,
  parameter int BYPASS_EN = 1,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  instruction_type             instruction,
  input  logic [XLEN-1:0]             pc,
  input  branch_predict_type          branch_in,
  input  logic                        flush,
  input  logic [NUM_WR-1:0]           write_en,
  input  logic [NUM_WR-1:0][RW-1:0]   write_id,
  input  logic [NUM_WR-1:0][XLEN-1:0] write_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output branch_predict_type          branch_out,
  output logic [RW-1:0]               reg_rd_id,
  output logic [XLEN-1:0]             pc_out,
  output logic [XLEN-1:0]             read_data1,
  output logic [XLEN-1:0]             read_data2,
  output logic [XLEN-1:0]             immediate_data,
  output control_type                 control_signals
);

  logic [RW-1:0]   rs1_id, rs2_id, rd_id;
  logic [RW-1:0]   rs1_q, rs2_q;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] ref1_data, ref2_data;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  control_type     ctrl_dec;
  logic            accept;

  assign rs1_id   = instruction[15 +: RW];
  assign rs2_id   = instruction[20 +: RW];
  assign rd_id    = instruction[7 +: RW];
  assign imm32    = decode_immediate(instruction);
  assign imm_ext  = XLEN'($signed(imm32));
  assign ctrl_dec = decode_control(instruction);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  id_regfile #(
    .XLEN      (XLEN),
    .NUM_REGS  (NUM_REGS),
    .NUM_WR    (NUM_WR),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .write_en   (write_en),
    .write_id   (write_id),
    .write_data (write_data),
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data)
  );

  // Refresh values for the held operands: last matching port wins, x0 never matches.
  always_comb begin
    ref1_data = read_data1;
    ref2_data = read_data2;
    for (int p = 0; p < NUM_WR; p++) begin
      if (write_en[p] && (write_id[p] == rs1_q) && (rs1_q != '0)) ref1_data = write_data[p];
      if (write_en[p] && (write_id[p] == rs2_q) && (rs2_q != '0)) ref2_data = write_data[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      branch_out      <= '0;
      reg_rd_id       <= '0;
      pc_out          <= '0;
      read_data1      <= '0;
      read_data2      <= '0;
      immediate_data  <= '0;
      control_signals <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      branch_out      <= branch_in;
      reg_rd_id       <= rd_id;
      pc_out          <= pc;
      read_data1      <= rs1_data;
      read_data2      <= rs2_data;
      immediate_data  <= imm_ext;
      control_signals <= ctrl_dec;
      rs1_q           <= rs1_id;
      rs2_q           <= rs2_id;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      read_data1 <= ref1_data;
      read_data2 <= ref2_data;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed vectors with hand-written
// decode expectations, a transaction-level model of the regfile and the
// output bundle, a per-cycle compare process, and literal spot checks.
module tb_id_stage_pipe;
  import common::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NWR  = 2;
  localparam int RW   = 5;
  localparam int BYP  = 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  instruction_type          instruction;
  logic [XLEN-1:0]          pc;
  branch_predict_type       branch_in;
  logic                     flush;
  logic [NWR-1:0]           write_en;
  logic [NWR-1:0][RW-1:0]   write_id;
  logic [NWR-1:0][XLEN-1:0] write_data;
  logic                     out_valid;
  logic                     out_ready;
  branch_predict_type       branch_out;
  logic [RW-1:0]            reg_rd_id;
  logic [XLEN-1:0]          pc_out;
  logic [XLEN-1:0]          read_data1;
  logic [XLEN-1:0]          read_data2;
  logic [XLEN-1:0]          immediate_data;
  control_type              control_signals;

  id_stage_pipe #(
    .XLEN(XLEN), .NUM_REGS(NREG), .NUM_WR(NWR), .BYPASS_EN(BYP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .branch_in(branch_in), .flush(flush),
    .write_en(write_en), .write_id(write_id), .write_data(write_data),
    .out_valid(out_valid), .out_ready(out_ready), .branch_out(branch_out),
    .reg_rd_id(reg_rd_id), .pc_out(pc_out), .read_data1(read_data1),
    .read_data2(read_data2), .immediate_data(immediate_data),
    .control_signals(control_signals)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic checking_on = 1'b0;

  // Hand-computed decode expectations travel with each vector.
  logic [XLEN-1:0] exp_imm;
  control_type     exp_ctrl;

  // Model state.
  logic [XLEN-1:0]    mregs [NREG];
  logic               m_valid;
  branch_predict_type m_branch;
  logic [RW-1:0]      m_rd, m_rs1, m_rs2;
  logic [XLEN-1:0]    m_pc, m_rd1, m_rd2, m_imm;
  control_type        m_ctrl;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Value seen for register id this cycle given the pending writes: last matching port wins.
  function automatic logic [XLEN-1:0] latest(input logic [RW-1:0] id, input logic [XLEN-1:0] dflt);
    logic [XLEN-1:0] v;
    v = dflt;
    for (int p = 0; p < NWR; p++)
      if (write_en[p] && write_id[p] == id && id != 0) v = write_data[p];
    return v;
  endfunction

  function automatic logic [XLEN-1:0] read_model(input logic [RW-1:0] id);
    logic [XLEN-1:0] v;
    v = (id == 0) ? '0 : mregs[id];
    if (BYP != 0) v = latest(id, v);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mregs[i] = '0;
      m_valid = 0; m_branch = '0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_ctrl = '0;
    end else begin
      if (flush) begin
        m_valid = 0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        m_valid  = 1;
        m_branch = branch_in;
        m_rd     = instruction[11:7];
        m_rs1    = instruction[19:15];
        m_rs2    = instruction[24:20];
        m_pc     = pc;
        m_rd1    = read_model(m_rs1);
        m_rd2    = read_model(m_rs2);
        m_imm    = exp_imm;
        m_ctrl   = exp_ctrl;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end else if (m_valid) begin
        m_rd1 = latest(m_rs1, m_rd1);
        m_rd2 = latest(m_rs2, m_rd2);
      end
      for (int p = 0; p < NWR; p++)
        if (write_en[p] && write_id[p] != 0) mregs[write_id[p]] = write_data[p];
    end
  end

  always @(negedge clk) begin
    if (checking_on) begin
      checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
      checkOutput("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      checkOutput("branch_out", 64'(branch_out), 64'(m_branch));
      checkOutput("reg_rd_id", 64'(reg_rd_id), 64'(m_rd));
      checkOutput("pc_out", 64'(pc_out), 64'(m_pc));
      checkOutput("read_data1", 64'(read_data1), 64'(m_rd1));
      checkOutput("read_data2", 64'(read_data2), 64'(m_rd2));
      checkOutput("immediate_data", 64'(immediate_data), 64'(m_imm));
      checkOutput("control_signals", 64'(control_signals), 64'(m_ctrl));
    end
  end

  function automatic instruction_type rtype(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic instruction_type itype(input int rd, input int rs1, input logic [11:0] imm);
    return {imm, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic iv, input instruction_type ins, input logic [XLEN-1:0] p,
                               input branch_predict_type br, input logic fl, input logic ordy,
                               input logic [XLEN-1:0] eimm, input control_type ectrl);
    in_valid = iv; instruction = ins; pc = p; branch_in = br;
    flush = fl; out_ready = ordy; exp_imm = eimm; exp_ctrl = ectrl;
  endtask

  task automatic setWrites(input logic e0, input int i0, input logic [XLEN-1:0] d0,
                           input logic e1, input int i1, input logic [XLEN-1:0] d1);
    write_en[0] = e0; write_id[0] = 5'(i0); write_data[0] = d0;
    write_en[1] = e1; write_id[1] = 5'(i1); write_data[1] = d1;
  endtask

  localparam control_type CTRL_ADD  = control_type'(10'h200);
  localparam control_type CTRL_ADDI = control_type'(10'h210);
  localparam control_type CTRL_SW   = control_type'(10'h090);
  localparam control_type CTRL_NONE = control_type'(10'h000);

  initial begin
    branch_predict_type br0, br1;
    br0 = '0;
    br1 = '{taken: 1'b1, target: 32'h0000_1000};
    rst = 1'b1;
    applyStimulus(0, '0, '0, br0, 0, 1, '0, CTRL_NONE);
    setWrites(0, 0, 0, 0, 0, 0);
    step();
    checking_on = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset read_data1", 64'(read_data1), 64'd0);
    checkOutput("reset control", 64'(control_signals), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);

    // Reads after reset are zero.
    applyStimulus(1, rtype(10, 3, 4), 32'h100, br1, 0, 1, 32'h0, CTRL_ADD);
    step();
    applyStimulus(0, '0, '0, br0, 0, 1, '0, CTRL_NONE);
    checkOutput("post-reset read", 64'(read_data1), 64'd0);
    checkOutput("post-reset rd", 64'(reg_rd_id), 64'd10);

    // Write then read next cycle.
    setWrites(1, 5, 32'h1234, 0, 0, 0);
    step();
    setWrites(0, 0, 0, 0, 0, 0);
    applyStimulus(1, rtype(1, 5, 0), 32'h104, br0, 0, 1, 32'h0, CTRL_ADD);
    step();
    checkOutput("x5 read", 64'(read_data1), 64'h1234);
    checkOutput("x5 rd", 64'(reg_rd_id), 64'd1);

    // Two ports hit x7 on the accept cycle: port 1 wins through the bypass.
    setWrites(1, 7, 32'hAAAA, 1, 7, 32'hBBBB);
    applyStimulus(1, rtype(2, 7, 7), 32'h108, br1, 0, 1, 32'h0, CTRL_ADD);
    step();
    setWrites(0, 0, 0, 0, 0, 0);
    checkOutput("bypass rs1", 64'(read_data1), 64'hBBBB);
    checkOutput("bypass rs2", 64'(read_data2), 64'hBBBB);
    applyStimulus(1, rtype(2, 7, 0), 32'h10C, br0, 0, 1, 32'h0, CTRL_ADD);
    step();
    checkOutput("x7 stored", 64'(read_data1), 64'hBBBB);

    // Stall with refresh.
    setWrites(1, 4, 32'h44, 1, 6, 32'h66);
    applyStimulus(0, '0, '0, br0, 0, 1, '0, CTRL_NONE);
    step();
    setWrites(0, 0, 0, 0, 0, 0);
    applyStimulus(1, rtype(3, 4, 6), 32'h110, br1, 0, 0, 32'h0, CTRL_ADD);
    step();
    checkOutput("held rs2", 64'(read_data2), 64'h66);
    setWrites(0, 0, 0, 1, 6, 32'h55);
    applyStimulus(1, itype(9, 4, 12'h007), 32'h200, br0, 0, 0, 32'h7, CTRL_ADDI);
    step();
    checkOutput("refresh rs2", 64'(read_data2), 64'h55);
    checkOutput("refresh rs1 kept", 64'(read_data1), 64'h44);
    checkOutput("stall pc", 64'(pc_out), 64'h110);
    checkOutput("stall in_ready", 64'(in_ready), 64'd0);
    setWrites(1, 6, 32'h11, 1, 6, 32'h22);
    step();
    setWrites(0, 0, 0, 0, 0, 0);
    checkOutput("refresh priority", 64'(read_data2), 64'h22);
    out_ready = 1'b1;
    step();
    checkOutput("back-to-back pc", 64'(pc_out), 64'h200);
    checkOutput("back-to-back valid", 64'(out_valid), 64'd1);

    // Flush drops the incoming instruction and the held one.
    applyStimulus(1, rtype(5, 1, 2), 32'h300, br1, 1, 0, 32'h0, CTRL_ADD);
    step();
    checkOutput("flush valid", 64'(out_valid), 64'd0);
    applyStimulus(0, '0, '0, br0, 0, 1, '0, CTRL_NONE);
    step();
    checkOutput("flush dropped", 64'(pc_out == 32'h300), 64'd0);

    // x0 writes are ignored, also on the bypass path.
    setWrites(1, 0, 32'hFFFF, 0, 0, 0);
    step();
    setWrites(0, 0, 0, 1, 0, 32'h1234);
    applyStimulus(1, itype(1, 0, 12'hFFF), 32'h400, br0, 0, 1, 32'hFFFF_FFFF, CTRL_ADDI);
    step();
    setWrites(0, 0, 0, 0, 0, 0);
    checkOutput("x0 read", 64'(read_data1), 64'd0);
    checkOutput("addi imm", 64'(immediate_data), 64'hFFFF_FFFF);

    // Store, LUI and an unknown opcode.
    applyStimulus(1, {7'b1111111, 5'd2, 5'd1, 3'b010, 5'b11100, 7'b0100011}, 32'h404, br1, 0, 1,
                  32'hFFFF_FFFC, CTRL_SW);
    step();
    checkOutput("sw imm", 64'(immediate_data), 64'hFFFF_FFFC);
    applyStimulus(1, {20'h12345, 5'd9, 7'b0110111}, 32'h408, br0, 0, 1, 32'h1234_5000, CTRL_ADDI);
    step();
    checkOutput("lui imm", 64'(immediate_data), 64'h1234_5000);
    applyStimulus(1, 32'hFFFF_FFFF, 32'h40C, br1, 0, 1, 32'h0, CTRL_NONE);
    step();
    checkOutput("nop ctrl", 64'(control_signals), 64'd0);
    checkOutput("nop valid", 64'(out_valid), 64'd1);

    // Reset in the middle of a stall clears bundle and regfile.
    applyStimulus(1, rtype(8, 5, 7), 32'h500, br1, 0, 0, 32'h0, CTRL_ADD);
    step();
    applyStimulus(0, '0, '0, br0, 0, 0, '0, CTRL_NONE);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid-stall reset valid", 64'(out_valid), 64'd0);
    checkOutput("mid-stall reset pc", 64'(pc_out), 64'd0);
    applyStimulus(1, rtype(1, 5, 7), 32'h504, br0, 0, 1, 32'h0, CTRL_ADD);
    step();
    checkOutput("cleared x5", 64'(read_data1), 64'd0);
    checkOutput("cleared x7", 64'(read_data2), 64'd0);

    applyStimulus(0, '0, '0, br0, 0, 1, '0, CTRL_NONE);
    step(); step();
    checking_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
